// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: FSM state and transaction owner encodings.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IFU  = 2'd1,
        OWN_LSU  = 2'd2
    } owner_t;

endpackage

// File: rtl/mem_arb_sel.sv
// Combinational winner selection between fetch and load/store requests.
// MEM_ARBITER_RR_EN switches conflicts from fixed LSU priority to round-robin.
module mem_arb_sel
    import mem_arb_pkg::*;
(
    input  logic   ifuValid,
    input  logic   lsuValid,
    input  owner_t lastGrant,
    output owner_t owner
);

`ifndef MEM_ARBITER_RR_EN
    logic unusedLastGrant;
    assign unusedLastGrant = ^lastGrant;
`endif

    // On a conflict the round-robin build favours whoever was not served last
    always_comb begin
        owner = OWN_NONE;
        if (ifuValid && lsuValid) begin
`ifdef MEM_ARBITER_RR_EN
            owner = (lastGrant == OWN_LSU) ? OWN_IFU : OWN_LSU;
`else
            owner = OWN_LSU;
`endif
        end else if (ifuValid) begin
            owner = OWN_IFU;
        end else if (lsuValid) begin
            owner = OWN_LSU;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store traffic onto one memory port, one transaction at a time.
// Define MEM_ARBITER_RR_EN for round-robin conflicts; default gives the LSU fixed priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0] ifu_addr,
    output logic                  ifu_resp_valid,
    output logic [DATA_WIDTH-1:0] ifu_rdata,
    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_addr,
    input  logic                  lsu_wen,
    input  logic [DATA_WIDTH-1:0] lsu_wdata,
    input  logic [7:0]            lsu_wmask,
    output logic                  lsu_resp_valid,
    output logic [DATA_WIDTH-1:0] lsu_rdata,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wen,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [7:0]            mem_wmask,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    state_t                state;
    owner_t                owner;
    owner_t                winner;
    owner_t                lastGrant;
    logic [ADDR_WIDTH-1:0] addrQ;
    logic                  wenQ;
    logic [DATA_WIDTH-1:0] wdataQ;
    logic [7:0]            wmaskQ;
    logic                  grantNow;
    logic                  respNow;

    mem_arb_sel uSel (
        .ifuValid  (ifu_req_valid),
        .lsuValid  (lsu_req_valid),
        .lastGrant (lastGrant),
        .owner     (winner)
    );

    // Every output is forced low while reset is asserted so nothing leaks from an abandoned transaction
    assign grantNow = !rst && (state == ST_IDLE);
    assign respNow  = !rst && (state == ST_RESP) && mem_resp_valid;

    assign ifu_req_ready  = grantNow && (winner == OWN_IFU);
    assign lsu_req_ready  = grantNow && (winner == OWN_LSU);
    assign ifu_resp_valid = respNow && (owner == OWN_IFU);
    assign lsu_resp_valid = respNow && (owner == OWN_LSU);
    assign ifu_rdata      = ifu_resp_valid ? mem_rdata : '0;
    assign lsu_rdata      = lsu_resp_valid ? mem_rdata : '0;

    assign mem_req_valid = !rst && (state == ST_REQ);
    assign mem_addr      = rst ? '0 : addrQ;
    assign mem_wen       = rst ? 1'b0 : wenQ;
    assign mem_wdata     = rst ? '0 : wdataQ;
    assign mem_wmask     = rst ? 8'h00 : wmaskQ;

`ifdef MEM_ARBITER_RR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            lastGrant <= OWN_LSU;
        end else if (grantNow && (winner != OWN_NONE)) begin
            lastGrant <= winner;
        end
    end
`else
    assign lastGrant = OWN_LSU;
`endif

    // Fields are captured at grant and held untouched until the next grant
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            owner  <= OWN_NONE;
            addrQ  <= '0;
            wenQ   <= 1'b0;
            wdataQ <= '0;
            wmaskQ <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (winner == OWN_IFU) begin
                        state  <= ST_REQ;
                        owner  <= OWN_IFU;
                        addrQ  <= ifu_addr;
                        wenQ   <= 1'b0;
                        wdataQ <= '0;
                        wmaskQ <= 8'h00;
                    end else if (winner == OWN_LSU) begin
                        state  <= ST_REQ;
                        owner  <= OWN_LSU;
                        addrQ  <= lsu_addr;
                        wenQ   <= lsu_wen;
                        wdataQ <= lsu_wdata;
                        wmaskQ <= lsu_wmask;
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (mem_resp_valid) begin
                        state <= ST_IDLE;
                        owner <= OWN_NONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    owner <= OWN_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level model checked every cycle plus directed literal checks.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_resp_valid;
    logic [31:0] ifu_rdata;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic [31:0] lsu_addr;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [7:0]  lsu_wmask;
    logic        lsu_resp_valid;
    logic [31:0] lsu_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;

    int nCompared = 0;
    int nMismatch = 0;

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_addr       (ifu_addr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_rdata      (ifu_rdata),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_addr       (lsu_addr),
        .lsu_wen        (lsu_wen),
        .lsu_wdata      (lsu_wdata),
        .lsu_wmask      (lsu_wmask),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_rdata      (lsu_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_wen        (mem_wen),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one pending transaction record, issued or not, plus grant history
    bit          mBusy = 1'b0;
    bit          mIssued = 1'b0;
    int          mOwn = 0;
    int          mLastG = 2;
    logic [31:0] mAddr = '0;
    logic        mWen = 1'b0;
    logic [31:0] mWdata = '0;
    logic [7:0]  mWmask = '0;
    int          grantLog[$];

    always @(negedge clk) begin
        int   win;
        logic eIfuRdy;
        logic eLsuRdy;
        logic eMemVld;
        logic eIfuResp;
        logic eLsuResp;
        win = 0;
        if (ifu_req_valid && lsu_req_valid) begin
`ifdef MEM_ARBITER_RR_EN
            win = (mLastG == 2) ? 1 : 2;
`else
            win = 2;
`endif
        end else if (ifu_req_valid) begin
            win = 1;
        end else if (lsu_req_valid) begin
            win = 2;
        end
        eIfuRdy  = !rst && !mBusy && (win == 1);
        eLsuRdy  = !rst && !mBusy && (win == 2);
        eMemVld  = !rst && mBusy && !mIssued;
        eIfuResp = !rst && mBusy && mIssued && (mOwn == 1) && mem_resp_valid;
        eLsuResp = !rst && mBusy && mIssued && (mOwn == 2) && mem_resp_valid;

        checkBit("ifuReady", ifu_req_ready, eIfuRdy);
        checkBit("lsuReady", lsu_req_ready, eLsuRdy);
        checkBit("memReqValid", mem_req_valid, eMemVld);
        checkBit("ifuRespValid", ifu_resp_valid, eIfuResp);
        checkBit("lsuRespValid", lsu_resp_valid, eLsuResp);
        checkOutput("ifuRdata", ifu_rdata, eIfuResp ? mem_rdata : 32'h0);
        checkOutput("lsuRdata", lsu_rdata, eLsuResp ? mem_rdata : 32'h0);
        checkOutput("memAddr", mem_addr, rst ? 32'h0 : mAddr);
        checkBit("memWen", mem_wen, rst ? 1'b0 : mWen);
        checkOutput("memWmask", {24'h0, mem_wmask}, rst ? 32'h0 : {24'h0, mWmask});
        if (rst || mOwn != 1) begin
            checkOutput("memWdata", mem_wdata, rst ? 32'h0 : mWdata);
        end

        if (rst) begin
            mBusy = 1'b0; mIssued = 1'b0; mOwn = 0; mLastG = 2;
            mAddr = '0; mWen = 1'b0; mWdata = '0; mWmask = '0;
        end else if (!mBusy) begin
            if (win != 0) begin
                mBusy = 1'b1; mIssued = 1'b0; mOwn = win; mLastG = win;
                grantLog.push_back(win);
                if (win == 1) begin
                    mAddr = ifu_addr; mWen = 1'b0; mWdata = '0; mWmask = '0;
                end else begin
                    mAddr = lsu_addr; mWen = lsu_wen; mWdata = lsu_wdata; mWmask = lsu_wmask;
                end
            end
        end else if (!mIssued) begin
            if (mem_req_ready) mIssued = 1'b1;
        end else if (mem_resp_valid) begin
            mBusy = 1'b0;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One arbitration window: raise the chosen valids, serve the winner with an immediate memory handshake
    task automatic applyStimulus(input bit useIfu, input bit useLsu, output int granted);
        ifu_req_valid = useIfu;
        ifu_addr      = 32'h8000_0004;
        lsu_req_valid = useLsu;
        lsu_addr      = 32'h8000_0200;
        lsu_wen       = 1'b0;
        #1;
        granted = ifu_req_ready ? 1 : (lsu_req_ready ? 2 : 0);
        tick;
        if (granted == 1) ifu_req_valid = 1'b0;
        if (granted == 2) lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = $urandom;
        tick;
        mem_resp_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int g;
        int base;
        int cnt;
        int expOrder[4];
`ifdef MEM_ARBITER_RR_EN
        expOrder = '{1, 2, 1, 2};
`else
        expOrder = '{2, 2, 2, 1};
`endif
        rst = 1'b1;
        ifu_req_valid = 1'b0; ifu_addr = '0;
        lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
        tick;
        ifu_req_valid = 1'b1;
        #1;
        checkBit("rstIfuReady", ifu_req_ready, 1'b0);
        checkBit("rstMemValid", mem_req_valid, 1'b0);
        tick;
        ifu_req_valid = 1'b0;
        rst = 1'b0;
        #1;
        checkOutput("postRstAddr", mem_addr, 32'h0);

        // Stray memory response while idle
        mem_resp_valid = 1'b1;
        mem_rdata = 32'h1234_5678;
        #1;
        checkBit("strayIfuResp", ifu_resp_valid, 1'b0);
        checkBit("strayLsuResp", lsu_resp_valid, 1'b0);
        tick;
        mem_resp_valid = 1'b0;
        #1;
        checkBit("strayMemValid", mem_req_valid, 1'b0);

        // IFU-only fetch with immediate memory handshake
        ifu_req_valid = 1'b1;
        ifu_addr = 32'h8000_0000;
        #1;
        checkBit("fetchReady", ifu_req_ready, 1'b1);
        checkBit("fetchLsuReady", lsu_req_ready, 1'b0);
        tick;
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        checkBit("fetchMemValid", mem_req_valid, 1'b1);
        checkOutput("fetchAddr", mem_addr, 32'h8000_0000);
        checkBit("fetchWen", mem_wen, 1'b0);
        checkOutput("fetchWmask", {24'h0, mem_wmask}, 32'h0);
        tick;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata = 32'h0000_0413;
        #1;
        checkBit("fetchResp", ifu_resp_valid, 1'b1);
        checkOutput("fetchRdata", ifu_rdata, 32'h0000_0413);
        checkBit("fetchLsuResp", lsu_resp_valid, 1'b0);
        tick;
        mem_resp_valid = 1'b0;
        #1;
        checkBit("fetchRespPulse", ifu_resp_valid, 1'b0);

        // Store stalled by memory for five cycles
        lsu_req_valid = 1'b1; lsu_wen = 1'b1;
        lsu_addr = 32'h8000_0100; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 8'h0F;
        #1;
        checkBit("storeReady", lsu_req_ready, 1'b1);
        tick;
        lsu_req_valid = 1'b0;
        lsu_addr = 32'h0; lsu_wdata = 32'h0; lsu_wmask = 8'h00; lsu_wen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checkBit("stallValid", mem_req_valid, 1'b1);
            checkOutput("stallAddr", mem_addr, 32'h8000_0100);
            checkOutput("stallWdata", mem_wdata, 32'hDEAD_BEEF);
            checkOutput("stallWmask", {24'h0, mem_wmask}, 32'h0000_000F);
            checkBit("stallWen", mem_wen, 1'b1);
            tick;
        end
        mem_req_ready = 1'b1;
        tick;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (lsu_resp_valid) cnt++;
            tick;
            mem_resp_valid = 1'b0;
        end
        checkOutput("storeRespCount", cnt, 32'd1);

        // Conflicting requests over three idle windows, then the remaining requester alone
        base = grantLog.size();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, g);
            checkOutput("conflictGrant", g, expOrder[i]);
        end
        applyStimulus(expOrder[3] == 1, expOrder[3] == 2, g);
        checkOutput("followGrant", g, expOrder[3]);
        if (grantLog.size() < base + 4) begin
            checkOutput("modelGrantCount", grantLog.size(), base + 4);
        end else begin
            for (int i = 0; i < 4; i++) checkOutput("modelGrantOrder", grantLog[base + i], expOrder[i]);
        end
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        tick;

        // Reset while an LSU load is waiting for its response
        lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_0010;
        tick;
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick;
        mem_req_ready = 1'b0;
        rst = 1'b1;
        mem_resp_valid = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        #1;
        checkBit("midRstLsuResp", lsu_resp_valid, 1'b0);
        checkOutput("midRstLsuRdata", lsu_rdata, 32'h0);
        checkOutput("midRstAddr", mem_addr, 32'h0);
        tick;
        rst = 1'b0;
        mem_resp_valid = 1'b0;
        #1;
        checkOutput("afterRstAddr", mem_addr, 32'h0);
        checkBit("afterRstMemValid", mem_req_valid, 1'b0);
        checkBit("afterRstLsuResp", lsu_resp_valid, 1'b0);
        mem_resp_valid = 1'b1;
        #1;
        checkBit("afterRstStray", lsu_resp_valid, 1'b0);
        tick;
        mem_resp_valid = 1'b0;

        // Fetch after reset with a two-cycle memory stall
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0040;
        tick;
        ifu_req_valid = 1'b0;
        repeat (2) tick;
        mem_req_ready = 1'b1;
        tick;
        mem_req_ready = 1'b0;
        tick;
        mem_resp_valid = 1'b1;
        mem_rdata = 32'h0051_3023;
        #1;
        checkOutput("lateFetchRdata", ifu_rdata, 32'h0051_3023);
        tick;
        mem_resp_valid = 1'b0;
        repeat (3) tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
